// File: rtl/bcd_seq_converter_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_seq_converter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } conv_state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] SAT_DIGIT = 4'd9;
  localparam logic [BCD_W-1:0] ADD3_THRESHOLD = 4'd5;

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble digit correction: values of 5 or more get 3 added before the shift.
module bcd_add3_digit
  import bcd_seq_converter_pkg::*;
(
  input  logic [BCD_W-1:0] digit_in,
  output logic [BCD_W-1:0] digit_out
);

  // A valid BCD digit is at most 9, so the adjusted value (at most 12) still fits in 4 bits.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= ADD3_THRESHOLD) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential shift-and-add-3 converter: one WIDTH-bit value per start, saturating to all nines on overflow.
module bcd_seq_converter
  import bcd_seq_converter_pkg::*;
#(
  parameter int WIDTH      = 14,
  parameter int DIGITS     = 4,
  parameter int SCR_DIGITS = 5
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     iSTART,
  input  logic [WIDTH-1:0]         iVALUE,
  output logic                     oBUSY,
  output logic                     oDONE,
  output logic                     oOVF,
  output logic [BCD_W*DIGITS-1:0]  oBCD
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SCR_W = BCD_W * SCR_DIGITS;
  localparam int OUT_W = BCD_W * DIGITS;

  conv_state_t        state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]   shift_reg;
  logic [SCR_W-1:0]   scratch;
  logic [SCR_W-1:0]   scratch_adj;
  logic               upper_nonzero;

  for (genvar d = 0; d < SCR_DIGITS; d++) begin : g_adjust
    bcd_add3_digit u_adjust (
      .digit_in  (scratch[d*BCD_W +: BCD_W]),
      .digit_out (scratch_adj[d*BCD_W +: BCD_W])
    );
  end

  // Any non-zero digit above the presented ones means the value did not fit.
  assign upper_nonzero = |scratch[SCR_W-1:OUT_W];

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      oBCD      <= '0;
      oOVF      <= 1'b0;
      oDONE     <= 1'b0;
      oBUSY     <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iSTART) begin
            shift_reg <= iVALUE;
            scratch   <= '0;
            bit_cnt   <= '0;
            oBUSY     <= 1'b1;
            state     <= CONV;
          end
        end
        CONV: begin
          scratch   <= {scratch_adj[SCR_W-2:0], shift_reg[WIDTH-1]};
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          bit_cnt   <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          if (upper_nonzero) begin
            oBCD <= {DIGITS{SAT_DIGIT}};
            oOVF <= 1'b1;
          end else begin
            oBCD <= scratch[OUT_W-1:0];
            oOVF <= 1'b0;
          end
          oDONE <= 1'b1;
          oBUSY <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
